piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
Parallel-in, serial-out shift transmitter. It is the sending end for the serial-in parallel-out shift register receiver. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first, one bit per bit-strobe. A receiver that shifts its input into the LSB therefore holds the original word after WIDTH bits. Frame and last-bit markers let downstream logic know when the receiver's parallel word is complete.

Parameters:
WIDTH, 8, word width in bits (>= 2)
IDLE_LEVEL, 1'b0, level driven on so while no frame is active
CNT_W, $clog2(WIDTH), width of the bit counter (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pi_data  input  WIDTH  parallel word to transmit
pi_valid  input  1  pi_data is valid; must hold data stable until accepted
pi_ready  output  1  transmitter can accept a word this cycle
shift_en  input  1  bit-rate strobe; tie high for one bit per clk
so  output  1  serial data out, MSB first
so_frame  output  1  high while so carries a frame bit
so_last  output  1  high while so carries the final (LSB) bit
tx_done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, shreg=0, bit_cnt=0, so=IDLE_LEVEL, so_frame=0, so_last=0, tx_done=0.
- pi_ready is high during reset release only once state=IDLE.
- FSM has two states: IDLE and SHIFT.
- IDLE:
  - pi_ready=1, so=IDLE_LEVEL.
  - On a clk edge with pi_valid=1: shreg<=pi_data, bit_cnt<=WIDTH-1, state<=SHIFT.
  - shift_en is ignored in IDLE.
- SHIFT:
  - so=shreg[WIDTH-1], taken from the register (no combinational path from pi_data).
  - so_frame=1.
  - so_last=(bit_cnt==0).
- Edge with shift_en=1 and bit_cnt!=0: shreg<=shreg<<1, bit_cnt<=bit_cnt-1.
- Edge with shift_en=0: all state holds, so the current bit stays on so.
- Edge with shift_en=1 and bit_cnt==0 (the last bit is consumed):
  - tx_done<=1 on the next cycle.
  - If pi_valid=1: load the next word (shreg<=pi_data, bit_cnt<=WIDTH-1), stay in SHIFT. This is back-to-back operation with zero idle bits.
  - Otherwise go to IDLE.
- pi_ready = (state==IDLE) | (state==SHIFT & bit_cnt==0 & shift_en). This is combinational from shift_en.
- Handshake: a transfer happens only on an edge with pi_valid & pi_ready. pi_valid asserted while pi_ready=0 has no effect.
- Latency:
  - The first bit appears on so in the cycle after acceptance.
  - With shift_en tied high, a frame occupies exactly WIDTH cycles.
  - tx_done rises WIDTH+1 cycles after acceptance.
- tx_done is registered and lasts exactly one cycle per frame, including in back-to-back operation.
- Reset mid-frame aborts immediately: so returns to IDLE_LEVEL, so_frame=0, and no tx_done is issued for the partial frame.
- bit_cnt never wraps: it is reloaded only on an accept.

Decomposition:
- Shared package piso_pkg holds:
  - state enum tx_state_t {TX_IDLE, TX_SHIFT}
  - a localparam/function for CNT_W
- No sub-module. The counter, the shift register and the two-state FSM stay in one always block plus output assigns.

Test Plan:
- Single word: reset, then pi_data=8'hA5 with pi_valid for one accepted cycle, shift_en=1.
  - so = 1,0,1,0,0,1,0,1 on cycles 1..8.
  - so_last on cycle 8; tx_done on cycle 9.
  - Looped into the SIPO receiver, it gives PO=8'hA5 at cycle 9.
- Back-to-back: 8'hA5 then 8'h3C held valid. The second word is accepted on the last-bit cycle of the first.
  - so_frame stays high 16 cycles; so = A5 bits then 0,0,1,1,1,1,0,0.
  - Two tx_done pulses, 8 cycles apart.
- Bit strobe: shift_en high every 3rd cycle, pi_data=8'h81.
  - Each bit is held 3 cycles.
  - so=1 for the first 3 cycles, 0 for 18 cycles, 1 for the final 3.
- Busy stall: during a frame, pi_valid=1 with 8'hFF while pi_ready=0.
  - The current frame is unaffected.
  - 8'hFF is accepted only on the last-bit cycle.
- Reset mid-frame: assert rst_n=0 after 4 bits of 8'hF0.
  - Asynchronously: so=IDLE_LEVEL, so_frame=0, pi_ready=0.
  - After release: pi_ready=1, no tx_done.
- Idle level: IDLE_LEVEL=1 build, no traffic → so=1 and so_frame=0 continuously after reset.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared types for the parallel-in serial-out transmitter.
// Holds the FSM state enum and the bit-counter width helper.
package piso_pkg;

   typedef enum logic {
      TX_IDLE,
      TX_SHIFT
   } tx_state_t;

   // Counter must hold WIDTH-1; WIDTH >= 2 keeps this at least 1 bit.
   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: valid/ready word in, MSB-first serial bit stream out.
// Back-to-back words are reloaded on the last-bit strobe with no gap.
module piso_shift_tx
   import piso_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pi_data,
   input  logic             pi_valid,
   output logic             pi_ready,
   input  logic             shift_en,
   output logic             so,
   output logic             so_frame,
   output logic             so_last,
   output logic             tx_done
);

   localparam int CNT_W = cnt_w(WIDTH);

   tx_state_t        state;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic             cnt_zero;
   logic             accept;

   assign cnt_zero = (bit_cnt == '0);

   // Ready while idle, or on the strobe that consumes the final bit.
   assign pi_ready = rst_n &
                     ((state == TX_IDLE) |
                      ((state == TX_SHIFT) & cnt_zero & shift_en));

   assign accept = pi_valid & pi_ready;

   // Serial outputs come only from registered state, never from pi_data.
   assign so       = (state == TX_SHIFT) ? shreg[WIDTH-1] : IDLE_LEVEL;
   assign so_frame = (state == TX_SHIFT);
   assign so_last  = (state == TX_SHIFT) & cnt_zero;

   // FSM, shift register, bit counter and done pulse in one block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= TX_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         unique case (1'b1)
            (state == TX_IDLE): begin
               if (accept) begin
                  shreg   <= pi_data;
                  bit_cnt <= CNT_W'(WIDTH - 1);
                  state   <= TX_SHIFT;
               end
            end
            (state == TX_SHIFT): begin
               if (shift_en) begin
                  if (!cnt_zero) begin
                     shreg   <= shreg << 1;
                     bit_cnt <= bit_cnt - 1'b1;
                  end else begin
                     tx_done <= 1'b1;
                     if (accept) begin
                        shreg   <= pi_data;
                        bit_cnt <= CNT_W'(WIDTH - 1);
                     end else begin
                        state <= TX_IDLE;
                     end
                  end
               end
            end
            default: begin
               state <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: table-driven check of piso_shift_tx, plus a mid-frame
// reset sequence and an IDLE_LEVEL=1 instance left without traffic.
module tb_piso_shift_tx;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       se;
      logic       rdy;
      logic       so;
      logic       fr;
      logic       la;
      logic       dn;
      logic       use_po;
      logic [7:0] po;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pi_data;
   logic       pi_valid;
   logic       shift_en;
   logic       pi_ready, so, so_frame, so_last, tx_done;
   logic       r1, so1, fr1, la1, dn1;

   int   n_vec = 0;
   int   n_err = 0;
   int   row   = -1;
   logic [7:0] po;
   vec_t tbl[$];

   always #5 clk = ~clk;

   piso_shift_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .pi_data(pi_data),
      .pi_valid(pi_valid), .pi_ready(pi_ready), .shift_en(shift_en),
      .so(so), .so_frame(so_frame), .so_last(so_last), .tx_done(tx_done)
   );

   piso_shift_tx #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut_hi (
      .clk(clk), .rst_n(rst_n), .pi_data(8'h00),
      .pi_valid(1'b0), .pi_ready(r1), .shift_en(1'b1),
      .so(so1), .so_frame(fr1), .so_last(la1), .tx_done(dn1)
   );

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic se,
                      input logic rdy, input logic s, input logic fr,
                      input logic la, input logic dn);
      vec_t e;
      e.v = v; e.d = d; e.se = se; e.rdy = rdy; e.so = s;
      e.fr = fr; e.la = la; e.dn = dn; e.use_po = 1'b0; e.po = 8'h00;
      tbl.push_back(e);
   endtask

   // Eight full-rate bit rows of word w; next word held on v/d.
   task automatic add_bits(input logic [7:0] w, input logic v,
                           input logic [7:0] d, input logic first_dn);
      for (int i = 0; i < 8; i++)
         add(v, d, 1'b1, (i == 7), w[7-i], 1'b1, (i == 7),
             (i == 0) && first_dn);
   endtask

   task automatic add_idle();
      add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic add_done(input logic se);
      add(1'b0, 8'h00, se, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic check_hi();
      chk("hi_so", {7'd0, so1}, 8'h01);
      chk("hi_frame", {7'd0, fr1}, 8'h00);
   endtask

   task automatic check_outs(input logic rdy, input logic s,
                             input logic fr, input logic la,
                             input logic dn);
      chk("ready", {7'd0, pi_ready}, {7'd0, rdy});
      chk("so", {7'd0, so}, {7'd0, s});
      chk("frame", {7'd0, so_frame}, {7'd0, fr});
      chk("last", {7'd0, so_last}, {7'd0, la});
      chk("done", {7'd0, tx_done}, {7'd0, dn});
      check_hi();
   endtask

   initial begin
      logic [7:0] w81;
      logic [7:0] w0f;
      vec_t       e;
      w81 = 8'h81;
      w0f = 8'h0F;

      // single word A5, receiver model result checked on done row
      add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add_bits(8'hA5, 1'b0, 8'h00, 1'b0);
      add_done(1'b1);
      tbl[tbl.size()-1].use_po = 1'b1;
      tbl[tbl.size()-1].po = 8'hA5;
      add_idle();

      // back-to-back A5 then 3C
      add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add_bits(8'hA5, 1'b1, 8'h3C, 1'b0);
      add_bits(8'h3C, 1'b0, 8'h00, 1'b1);
      add_done(1'b1);
      tbl[tbl.size()-1].use_po = 1'b1;
      tbl[tbl.size()-1].po = 8'h3C;
      add_idle();

      // strobe every third cycle, 81; accepted with shift_en low
      add(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 24; c++) begin
         int  bi;
         logic se;
         bi = (c - 1) / 3;
         se = (c % 3 == 0);
         add(1'b0, 8'h00, se, (bi == 7) && se, w81[7-bi], 1'b1,
             (bi == 7), 1'b0);
      end
      add_done(1'b0);
      add_idle();

      // busy stall: FF offered during 0F, last strobe delayed one cycle
      add(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++)
         add(1'b1, 8'hFF, 1'b1, 1'b0, w0f[7-i], 1'b1, 1'b0, 1'b0);
      add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      add(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      add_bits(8'hFF, 1'b0, 8'h00, 1'b1);
      add_done(1'b1);
      add_idle();

      rst_n    = 1'b0;
      pi_valid = 1'b0;
      pi_data  = 8'h00;
      shift_en = 1'b0;
      po       = 8'h00;

      #12;
      check_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check_outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < tbl.size(); k++) begin
         e = tbl[k];
         @(negedge clk);
         row      = k;
         pi_valid = e.v;
         pi_data  = e.d;
         shift_en = e.se;
         #2;
         check_outs(e.rdy, e.so, e.fr, e.la, e.dn);
         if (e.use_po) chk("sipo_po", po, e.po);
         if (so_frame && shift_en) po = {po[6:0], so};
      end

      // mid-frame reset after four bits of F0
      row = 1000;
      @(negedge clk);
      pi_valid = 1'b1; pi_data = 8'hF0; shift_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pi_valid = 1'b0;
         #2;
         chk("mid_so", {7'd0, so}, 8'h01);
      end
      @(negedge clk);
      #2;
      chk("mid_frame", {7'd0, so_frame}, 8'h01);
      chk("mid_so4", {7'd0, so}, 8'h00);
      rst_n = 1'b0;
      #1;
      check_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check_outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #2;
         check_outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
